irq_arbiter: RTL

Interrupt request arbiter sitting directly upstream of the CP0 register block. Edge-detects three external interrupt lines, latches them as pending, masks them with CP0's INM field, and picks the highest-priority request. When the pipeline can take it, the block issues the break pulse, interrupt code and new-IE value that CP0 consumes, plus a handler vector for the PC-select logic. It tracks nested interrupt levels on a small stack that is popped on `eret`.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/irq_edge_latch.sv | 27 ++
 rtl/irq_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared interrupt constants, code encodings and the vector helper
package cpu_pkg;
    localparam int IRQ_NUM = 3;
    localparam int LVL_W   = 2;
    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;
    typedef enum logic [LVL_W-1:0] {
        CODE_NONE = 2'd0,
        CODE_SRC1 = 2'd1,
        CODE_SRC2 = 2'd2,
        CODE_SRC3 = 2'd3
    } irq_code_t;
    // Handler entry for a code; plain 32-bit arithmetic so it wraps modulo 2^32.
    function automatic logic [31:0] vec_of(input logic [31:0] base, input logic [31:0] stride,
                                           input logic [LVL_W-1:0] code);
        return base + 32'(code) * stride;
    endfunction
endpackage

// File: rtl/irq_edge_latch.sv
// irq_edge_latch: rising-edge detector with a pending bit whose set beats its clear
// Ports: i_clk/i_rst clock and sync reset, i_irq raw line, i_clr clear request
// (a take of this source), o_pend pending bit.
module irq_edge_latch (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_irq,
    input  logic i_clr,
    output logic o_pend
);
    logic r_hist;
    logic r_pend;
    logic w_rise;

    assign w_rise = i_irq & ~r_hist;
    assign o_pend = r_pend;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_hist <= i_irq;
            r_pend <= w_rise | (r_pend & ~i_clr);
        end
    end
endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: latches, masks and prioritises external IRQs and tracks nested levels for CP0
// Ports: in_CLK/in_RST clock and sync reset; in_IRQ raw lines (bit i-1 = source i);
// in_IE, in_INM from CP0; in_STALL blocks takes; in_ERET pops a level.
// out_BK/out_code/out_NIE feed CP0, out_VEC feeds PC select, out_PEND/out_LEVEL are status.
module irq_arbiter
    import cpu_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic               in_CLK,
    input  logic               in_RST,
    input  logic [IRQ_NUM-1:0] in_IRQ,
    input  logic               in_IE,
    input  logic [3:0]         in_INM,
    input  logic               in_STALL,
    input  logic               in_ERET,
    output logic               out_BK,
    output logic [LVL_W-1:0]   out_code,
    output logic               out_NIE,
    output logic [31:0]        out_VEC,
    output logic [IRQ_NUM-1:0] out_PEND,
    output logic [LVL_W-1:0]   out_LEVEL
);
    logic [IRQ_NUM-1:0] w_pend;
    logic [IRQ_NUM-1:0] w_clr;
    logic [3:0]         w_req;
    logic [LVL_W-1:0]   w_cand;
    logic [LVL_W-1:0]   w_level;
    logic               w_take;

    logic [LVL_W-1:0]   r_stk [IRQ_NUM];
    logic [LVL_W-1:0]   r_depth;
    logic               r_bk;
    logic [LVL_W-1:0]   r_code;
    logic [31:0]        r_vec;

    for (genvar g = 0; g < IRQ_NUM; g++) begin : g_src
        irq_edge_latch u_latch (
            .i_clk  (in_CLK),
            .i_rst  (in_RST),
            .i_irq  (in_IRQ[g]),
            .i_clr  (w_clr[g]),
            .o_pend (w_pend[g])
        );
        assign w_clr[g] = w_take & (w_cand == LVL_W'(g + 1));
    end

    // Bit 0 of INM has no source behind it, so w_req[0] is always 0.
    assign w_req  = {w_pend, 1'b0} & ~in_INM;
    assign w_cand = w_req[3] ? CODE_SRC3 : w_req[2] ? CODE_SRC2 : w_req[1] ? CODE_SRC1 : CODE_NONE;

    // Current level is the top of the stack.
    assign w_level = (r_depth == 2'd3) ? r_stk[2] :
                     (r_depth == 2'd2) ? r_stk[1] :
                     (r_depth == 2'd1) ? r_stk[0] : CODE_NONE;

    // Suppressing during r_bk covers the cycle before CP0's IE clear is visible;
    // ERET defers the take so it is judged against the popped level.
    assign w_take = in_IE & ~in_STALL & ~r_bk & ~in_ERET & (w_cand > w_level) & (r_depth < 2'd3);

    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            for (int i = 0; i < IRQ_NUM; i++) r_stk[i] <= '0;
            r_depth <= '0;
            r_bk    <= 1'b0;
            r_code  <= '0;
            r_vec   <= '0;
        end else begin
            r_bk   <= w_take;
            r_code <= w_take ? w_cand : CODE_NONE;
            if (w_take) begin
                r_vec          <= vec_of(VEC_BASE, VEC_STRIDE, w_cand);
                r_stk[r_depth] <= w_cand;
                r_depth        <= r_depth + 2'd1;
            end else if (in_ERET && r_depth != 2'd0) begin
                r_depth <= r_depth - 2'd1;
            end
        end
    end

    assign out_BK    = r_bk;
    assign out_code  = r_code;
    assign out_NIE   = ~r_bk;
    assign out_VEC   = r_vec;
    assign out_PEND  = w_pend;
    assign out_LEVEL = w_level;
endmodule
